// File: rtl/platform_mem_pkg.sv
// Shared types and helpers for the dual-port on-chip RAM.
// Byte-lane merge is used by both the write path and the collision bypass.
package platform_mem_pkg;

   localparam int MIN_RL     = 1;
   localparam int MAX_RL     = 2;
   localparam int DEF_DATA_W = 32;
   localparam int BE_W       = DEF_DATA_W / 8;

   // Widest word the merge helper handles; callers size-cast in and out.
   localparam int MAX_DW = 1024;
   localparam int MAX_BE = MAX_DW / 8;

   function automatic logic [MAX_DW-1:0] be_merge(
      input logic [MAX_DW-1:0] old_d,
      input logic [MAX_DW-1:0] new_d,
      input logic [MAX_BE-1:0] be
   );
      logic [MAX_DW-1:0] r;
      r = old_d;
      for (int i = 0; i < MAX_BE; i++) begin
         if (be[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/platform_onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for one side of the dual-port RAM.
// Pipelined reads, no waitrequest.
interface platform_onchip_memory_dp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 13
);

   logic [ADDR_W-1:0]   address;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, chipselect, read, write,
      output byteenable, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, chipselect, read, write,
      input  byteenable, writedata,
      output readdata, readdatavalid
   );

endinterface

// File: rtl/platform_mem_rd_pipe.sv
// Read-return pipeline for one RAM port: valid/data shift register
// that stalls with en and zeroes data for out-of-range reads.
module platform_mem_rd_pipe
   import platform_mem_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              rd,
   input  logic              in_range,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);

   localparam int RL =
      (READ_LATENCY > MAX_RL) ? MAX_RL :
      (READ_LATENCY < MIN_RL) ? MIN_RL :
      READ_LATENCY;

   logic [RL-1:0]     vld;
   logic [DATA_W-1:0] dat [RL];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld <= '0;
         for (int i = 0; i < RL; i++) begin
            dat[i] <= '0;
         end
      end else if (en) begin
         vld[0] <= rd;
         dat[0] <= (rd && in_range) ? rdata : '0;
         for (int i = 1; i < RL; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   // A held result stays hidden until the block is enabled again.
   assign readdatavalid = vld[RL-1] & en;
   assign readdata      = dat[RL-1];

endmodule

// File: rtl/platform_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports.
// Same-address collisions resolve with s1 lanes winning and reads seeing new data.
module platform_onchip_memory_dp
   import platform_mem_pkg::*;
#(
   parameter int    DATA_W       = 32,
   parameter int    ADDR_W       = 13,
   parameter int    DEPTH        = 8192,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = ""
) (
   input logic clk,
   input logic reset,
   input logic reset_req,
   input logic clken,
   input logic freeze,
   platform_onchip_memory_dp_if.slave s1,
   platform_onchip_memory_dp_if.slave s2
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   reg [DATA_W-1:0] mem [0:DEPTH-1];

   logic              en;
   logic              go;
   logic              rng1;
   logic              rng2;
   logic              rd1;
   logic              rd2;
   logic              wr1;
   logic              wr2;
   logic              same;
   logic [IDX_W-1:0]  a1;
   logic [IDX_W-1:0]  a2;
   logic [DATA_W-1:0] q1;
   logic [DATA_W-1:0] q2;
   logic [DATA_W-1:0] wdat1;
   logic [DATA_W-1:0] wdat2;
   logic [DATA_W-1:0] rdat1;
   logic [DATA_W-1:0] rdat2;

   function automatic logic [DATA_W-1:0] merge(
      input logic [DATA_W-1:0]   o,
      input logic [DATA_W-1:0]   n,
      input logic [DATA_W/8-1:0] be
   );
      return DATA_W'(be_merge(MAX_DW'(o), MAX_DW'(n), MAX_BE'(be)));
   endfunction

   assign en   = clken & ~freeze & ~reset_req;
   assign go   = en & ~reset;

   assign rng1 = {1'b0, s1.address} < DEPTH_L;
   assign rng2 = {1'b0, s2.address} < DEPTH_L;

   // Write wins over read on the same port; out-of-range writes vanish.
   assign rd1  = go & s1.chipselect & s1.read & ~s1.write;
   assign rd2  = go & s2.chipselect & s2.read & ~s2.write;
   assign wr1  = go & s1.chipselect & s1.write & rng1;
   assign wr2  = go & s2.chipselect & s2.write & rng2;

   assign a1   = s1.address[IDX_W-1:0];
   assign a2   = s2.address[IDX_W-1:0];
   assign same = s1.address == s2.address;

   assign q1   = mem[a1];
   assign q2   = mem[a2];

   always_comb begin
      wdat2 = merge(q2, s2.writedata, s2.byteenable);
      wdat1 = merge((wr2 && same) ? wdat2 : q1,
                    s1.writedata, s1.byteenable);
      rdat1 = q1;
      rdat2 = q2;
      if (wr2 && same) begin
         rdat1 = merge(q1, s2.writedata, s2.byteenable);
      end
      if (wr1 && same) begin
         rdat2 = merge(q2, s1.writedata, s1.byteenable);
      end
   end

   // s1 is written last so its lanes take priority on a shared address.
   always_ff @(posedge clk) begin
      if (wr2) mem[a2] <= wdat2;
      if (wr1) mem[a1] <= wdat1;
   end

   platform_mem_rd_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe1 (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .rd            (rd1),
      .in_range      (rng1),
      .rdata         (rdat1),
      .readdata      (s1.readdata),
      .readdatavalid (s1.readdatavalid)
   );

   platform_mem_rd_pipe #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe2 (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .rd            (rd2),
      .in_range      (rng2),
      .rdata         (rdat2),
      .readdata      (s2.readdata),
      .readdatavalid (s2.readdatavalid)
   );

endmodule

// File: tb/tb_platform_onchip_memory_dp.sv
// Bench for platform_onchip_memory_dp: directed vectors on RL=1 and RL=2
// builds plus a randomized run against a queue-based reference model.
module tb_platform_onchip_memory_dp;

   localparam int DW    = 32;
   localparam int AW    = 13;
   localparam int DEPTH = 6000;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          cs;
      logic          rd;
      logic          wr;
      logic [3:0]    be;
      logic [31:0]   wd;
   } req_t;

   typedef struct {
      req_t        r1;
      req_t        r2;
      bit          ev1;
      logic [31:0] ed1;
      bit          ev2;
      logic [31:0] ed2;
   } vec_t;

   typedef struct {
      int          cnt;
      logic [31:0] data;
   } pend_t;

   localparam req_t IDLE = '0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [2];
   logic        rreq [2];
   logic        cke  [2];
   logic        frz  [2];
   req_t        rq   [2][2];
   logic [31:0] rdat [2][2];
   logic        rval [2][2];

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem_m [16];
   pend_t       pq [2][2][$];

   platform_onchip_memory_dp_if #(.DATA_W(DW), .ADDR_W(AW)) ifs [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_if
      assign ifs[g].address    = rq[g/2][g%2].addr;
      assign ifs[g].chipselect = rq[g/2][g%2].cs;
      assign ifs[g].read       = rq[g/2][g%2].rd;
      assign ifs[g].write      = rq[g/2][g%2].wr;
      assign ifs[g].byteenable = rq[g/2][g%2].be;
      assign ifs[g].writedata  = rq[g/2][g%2].wd;
      assign rdat[g/2][g%2]    = ifs[g].readdata;
      assign rval[g/2][g%2]    = ifs[g].readdatavalid;
   end

   platform_onchip_memory_dp #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
      .READ_LATENCY(1), .INIT_FILE("")
   ) dut_a (
      .clk(clk), .reset(rst[0]), .reset_req(rreq[0]),
      .clken(cke[0]), .freeze(frz[0]),
      .s1(ifs[0]), .s2(ifs[1])
   );

   platform_onchip_memory_dp #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
      .READ_LATENCY(2), .INIT_FILE("")
   ) dut_b (
      .clk(clk), .reset(rst[1]), .reset_req(rreq[1]),
      .clken(cke[1]), .freeze(frz[1]),
      .s1(ifs[2]), .s2(ifs[3])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic req_t mk(input int a, input bit r, input bit w,
                               input logic [3:0] be, input logic [31:0] wd);
      req_t x;
      x.addr = AW'(a);
      x.cs   = r | w;
      x.rd   = r;
      x.wr   = w;
      x.be   = be;
      x.wd   = wd;
      return x;
   endfunction

   function automatic req_t rdq(input int a);
      return mk(a, 1'b1, 1'b0, 4'h0, 32'h0);
   endfunction

   function automatic req_t wrq(input int a, input logic [3:0] be,
                                input logic [31:0] wd);
      return mk(a, 1'b0, 1'b1, be, wd);
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] o,
                                         input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] v;
      v = o;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) v[b*8 +: 8] = n[b*8 +: 8];
      end
      return v;
   endfunction

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) rq[d][p] = IDLE;
      end
   endtask

   // Reference: each accepted read waits RL-1 enabled edges, then shows
   // while enabled and retires on the next enabled edge.
   task automatic model_step();
      bit          en;
      bit          ev;
      bit          isw [2];
      bit          isr [2];
      bit          inr [2];
      req_t        r   [2];
      logic [31:0] v;
      pend_t       e;
      en = cke[0] & ~frz[0] & ~rreq[0];
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            ev = en && pq[d][p].size() > 0 && pq[d][p][0].cnt == 0;
            chk($sformatf("rnd_valid_d%0d_s%0d", d, p + 1),
                32'(rval[d][p]), 32'(ev));
            if (ev) begin
               chk($sformatf("rnd_data_d%0d_s%0d", d, p + 1),
                   rdat[d][p], pq[d][p][0].data);
            end
         end
      end
      if (en) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (pq[d][p].size() > 0 && pq[d][p][0].cnt == 0)
                  void'(pq[d][p].pop_front());
               for (int k = 0; k < pq[d][p].size(); k++)
                  pq[d][p][k].cnt = pq[d][p][k].cnt - 1;
            end
         end
         for (int p = 0; p < 2; p++) begin
            r[p]   = rq[0][p];
            inr[p] = 32'(r[p].addr) < 32'(DEPTH);
            isw[p] = r[p].cs && r[p].wr;
            isr[p] = r[p].cs && r[p].rd && !r[p].wr;
         end
         for (int p = 0; p < 2; p++) begin
            if (isr[p]) begin
               v = 32'h0;
               if (inr[p]) begin
                  v = mem_m[r[p].addr[3:0]];
                  if (isw[1-p] && r[1-p].addr == r[p].addr)
                     v = lanes(v, r[1-p].wd, r[1-p].be);
               end
               for (int d = 0; d < 2; d++) begin
                  e.cnt  = d;
                  e.data = v;
                  pq[d][p].push_back(e);
               end
            end
         end
         if (isw[1] && inr[1])
            mem_m[r[1].addr[3:0]] = lanes(mem_m[r[1].addr[3:0]], r[1].wd, r[1].be);
         if (isw[0] && inr[0])
            mem_m[r[0].addr[3:0]] = lanes(mem_m[r[0].addr[3:0]], r[0].wd, r[0].be);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [$];
      int          k;
      int          got;
      int          a;
      int          op;
      logic [31:0] w0;
      logic [31:0] w1;
      req_t        x;

      for (int d = 0; d < 2; d++) begin
         rst[d]  = 1'b1;
         rreq[d] = 1'b0;
         cke[d]  = 1'b1;
         frz[d]  = 1'b0;
      end
      idle_all();
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst_valid_d%0d_s%0d", d, p + 1), 32'(rval[d][p]), 32'h0);
            chk($sformatf("rst_data_d%0d_s%0d", d, p + 1), rdat[d][p], 32'h0);
         end
      end
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      vt.push_back('{wrq(16, 4'hF, 32'hDEADBEEF), IDLE, 1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{rdq(16), IDLE, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
      vt.push_back('{wrq(32, 4'hF, 32'h11223344), IDLE, 1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{IDLE, wrq(32, 4'b0101, 32'hAABBCCDD), 1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{IDLE, rdq(32), 1'b0, 32'h0, 1'b1, 32'h11BB33DD});
      vt.push_back('{wrq(5, 4'hF, 32'h0), IDLE, 1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{wrq(5, 4'hF, 32'hCAFEF00D), rdq(5), 1'b0, 32'h0, 1'b1, 32'hCAFEF00D});
      vt.push_back('{wrq(5, 4'b0001, 32'h000000FF), wrq(5, 4'hF, 32'h12345600),
                     1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{rdq(5), rdq(5), 1'b1, 32'h123456FF, 1'b1, 32'h123456FF});
      vt.push_back('{wrq(32, 4'b1000, 32'h99000000), rdq(32), 1'b0, 32'h0, 1'b1, 32'h99BB33DD});
      vt.push_back('{IDLE, wrq(32, 4'h0, 32'hFFFFFFFF), 1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{rdq(32), IDLE, 1'b1, 32'h99BB33DD, 1'b0, 32'h0});
      vt.push_back('{mk(48, 1'b1, 1'b1, 4'hF, 32'h01020304), IDLE, 1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{rdq(48), IDLE, 1'b1, 32'h01020304, 1'b0, 32'h0});
      vt.push_back('{rdq(48), wrq(48, 4'b0010, 32'h0000AB00), 1'b1, 32'h0102AB04, 1'b0, 32'h0});
      vt.push_back('{rdq(48), IDLE, 1'b1, 32'h0102AB04, 1'b0, 32'h0});
      vt.push_back('{wrq(1905, 4'hF, 32'h55AA55AA), IDLE, 1'b0, 32'h0, 1'b0, 32'h0});
      vt.push_back('{wrq(6001, 4'hF, 32'hFFFFFFFF), rdq(6001), 1'b0, 32'h0, 1'b1, 32'h0});
      vt.push_back('{rdq(1905), rdq(16), 1'b1, 32'h55AA55AA, 1'b1, 32'hDEADBEEF});
      vt.push_back('{IDLE, rdq(6000), 1'b0, 32'h0, 1'b1, 32'h0});

      foreach (vt[i]) begin
         @(posedge clk);
         #1;
         rq[0][0] = vt[i].r1;
         rq[0][1] = vt[i].r2;
         @(posedge clk);
         #1;
         idle_all();
         @(negedge clk);
         chk($sformatf("v%0d_s1_valid", i), 32'(rval[0][0]), 32'(vt[i].ev1));
         if (vt[i].ev1) chk($sformatf("v%0d_s1_data", i), rdat[0][0], vt[i].ed1);
         chk($sformatf("v%0d_s2_valid", i), 32'(rval[0][1]), 32'(vt[i].ev2));
         if (vt[i].ev2) chk($sformatf("v%0d_s2_data", i), rdat[0][1], vt[i].ed2);
      end

      // RL=2 back-to-back reads with a three-cycle freeze in the middle
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         rq[1][1] = wrq(i, 4'hF, 32'hA0000000 + i);
      end
      @(posedge clk);
      #1;
      idle_all();
      k   = 0;
      got = 0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk);
         #1;
         frz[1]   = (c >= 4 && c < 7);
         rq[1][0] = (k < 8) ? rdq(k) : IDLE;
         @(negedge clk);
         if (frz[1]) chk("t4_frozen_valid", 32'(rval[1][0]), 32'h0);
         if (rval[1][0]) begin
            chk($sformatf("t4_data_%0d", got), rdat[1][0], 32'hA0000000 + got);
            got++;
         end
         if (!frz[1] && k < 8) k++;
      end
      chk("t4_pulse_count", 32'(got), 32'd8);

      // RL=2 reset one edge after the read is accepted
      @(posedge clk);
      #1;
      rq[1][0] = rdq(3);
      @(posedge clk);
      #1;
      rq[1][0] = IDLE;
      @(posedge clk);
      #1;
      rst[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("t5_rst_valid_%0d", c), 32'(rval[1][0]), 32'h0);
         chk($sformatf("t5_rst_data_%0d", c), rdat[1][0], 32'h0);
      end
      @(posedge clk);
      #1;
      rst[1]   = 1'b0;
      rq[1][0] = rdq(3);
      @(posedge clk);
      #1;
      rq[1][0] = IDLE;
      @(negedge clk);
      chk("t5_early_valid", 32'(rval[1][0]), 32'h0);
      @(negedge clk);
      chk("t5_post_valid", 32'(rval[1][0]), 32'h1);
      chk("t5_post_data", rdat[1][0], 32'hA0000003);

      // Random run on both builds against the reference model
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         w0 = $urandom;
         w1 = $urandom;
         for (int d = 0; d < 2; d++) begin
            rq[d][0] = wrq(i, 4'hF, w0);
            rq[d][1] = wrq(i + 8, 4'hF, w1);
         end
         mem_m[i]     = w0;
         mem_m[i + 8] = w1;
      end
      @(posedge clk);
      #1;
      idle_all();
      repeat (4) @(posedge clk);

      for (int c = 0; c < 500; c++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            cke[d]  = 1'b1;
            frz[d]  = 1'b0;
            rreq[d] = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) begin
            cke[0] = 1'b0;
            cke[1] = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) begin
            frz[0] = 1'b1;
            frz[1] = 1'b1;
         end
         if ($urandom_range(0, 11) == 0) begin
            rreq[0] = 1'b1;
            rreq[1] = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            a  = ($urandom_range(0, 7) == 0) ? 6000 + $urandom_range(0, 3)
                                             : $urandom_range(0, 15);
            op = $urandom_range(0, 3);
            x  = mk(a, op != 1, op == 1 || op == 2,
                    4'($urandom_range(0, 15)), $urandom);
            x.cs = $urandom_range(0, 7) != 0;
            rq[0][p] = x;
            rq[1][p] = x;
         end
         @(negedge clk);
         model_step();
      end

      @(posedge clk);
      #1;
      idle_all();
      for (int d = 0; d < 2; d++) begin
         cke[d]  = 1'b1;
         frz[d]  = 1'b0;
         rreq[d] = 1'b0;
      end
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
